fetch_stage: RTL and testbench

- Instruction-fetch front end. Owns the PC and runs a single-outstanding request/response handshake with instruction memory.
- Presents instrF / PCF / PCPulse4F to the IF/ID register, with validF qualifying them.
- Honours StallF from the hazard unit and branch/jump redirects from execute (PCSrcE / PCTargetE).
- Drops responses that are in flight when a redirect occurs.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 tb/tb_fetch_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package  : riscv_pkg
// Purpose  : Definitions shared by the fetch front end and the decode/hazard
//            logic: datapath width, the canonical NOP encoding, and the
//            fetch-stage state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,   // request to instruction memory is being presented
    WAIT = 2'd1,   // one request accepted, response outstanding
    HOLD = 2'd2    // response captured, held while decode is stalled
  } fetch_state_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch front end. Owns the PC and runs a single-
//            outstanding request/response handshake with instruction memory,
//            presenting the fetched word to the IF/ID register.
// Ports    :
//   clk, rst              clock and synchronous active-high reset
//   StallF                hold the presented instruction, do not advance
//   PCSrcE, PCTargetE     redirect request and target from execute
//   imem_req, imem_addr   request to instruction memory (addr word aligned)
//   imem_gnt              request accepted this cycle
//   imem_rvalid/rdata     response from instruction memory
//   instrF, PCF,          instruction, its PC and PC+4 for the IF/ID register
//   PCPulse4F, validF     validF qualifies the three above
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPulse4F,
  output logic            validF
);

  fetch_state_t    state;
  logic [XLEN-1:0] pc_q;          // address of the next request
  logic [XLEN-1:0] req_pc_q;      // address of the outstanding request
  logic            kill_q;        // outstanding response must be discarded
  logic [XLEN-1:0] hold_instr_q;
  logic [XLEN-1:0] hold_pc_q;

  // --------------------------------------------------------------------------
  // State update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= RESET_PC;
      kill_q       <= 1'b0;
      state        <= IDLE;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (imem_gnt) begin
            req_pc_q <= pc_q;
            state    <= WAIT;
            // A redirect in the grant cycle makes this request stale.
            kill_q   <= PCSrcE;
          end
          if (PCSrcE) begin
            pc_q <= PCTargetE;
          end
        end

        WAIT: begin
          if (imem_rvalid) begin
            state  <= IDLE;
            kill_q <= 1'b0;
            if (PCSrcE) begin
              pc_q <= PCTargetE;
            end else if (!kill_q) begin
              if (StallF) begin
                hold_instr_q <= imem_rdata;
                hold_pc_q    <= req_pc_q;
                state        <= HOLD;
              end else begin
                pc_q <= req_pc_q + 32'd4;
              end
            end
          end else if (PCSrcE) begin
            // Response still in flight: mark it for discard on arrival.
            pc_q   <= PCTargetE;
            kill_q <= 1'b1;
          end
        end

        HOLD: begin
          if (PCSrcE) begin
            pc_q  <= PCTargetE;
            state <= IDLE;
          end else if (!StallF) begin
            pc_q  <= hold_pc_q + 32'd4;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. A live response is passed straight through in its arrival cycle
  // so a fetch costs only request + response cycles.
  // --------------------------------------------------------------------------
  always_comb begin
    imem_req  = (state == IDLE);
    imem_addr = {pc_q[XLEN-1:2], 2'b00};
    validF    = 1'b0;
    instrF    = NOP_INSTR;
    PCF       = pc_q;
    case (state)
      WAIT: begin
        if (imem_rvalid && !kill_q && !PCSrcE) begin
          validF = 1'b1;
          instrF = imem_rdata;
          PCF    = req_pc_q;
        end
      end
      HOLD: begin
        if (!PCSrcE) begin
          validF = 1'b1;
          instrF = hold_instr_q;
          PCF    = hold_pc_q;
        end
      end
      default: ;
    endcase
  end

  assign PCPulse4F = PCF + 32'd4;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Self-checking bench for fetch_stage. A transaction-level model
//            (next PC, one optional outstanding request, one optional held
//            instruction) predicts every output each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instrF;
  logic [31:0] PCF;
  logic [31:0] PCPulse4F;
  logic        validF;

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .StallF     (StallF),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instrF     (instrF),
    .PCF        (PCF),
    .PCPulse4F  (PCPulse4F),
    .validF     (validF)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: a fetch is either being requested, outstanding, or held.
  bit          m_ok = 0;          // model meaningful (after first reset)
  bit          m_after_rst = 0;
  logic [31:0] m_pc;
  bit          m_out;             // request granted, response not yet seen
  logic [31:0] m_out_pc;
  bit          m_out_dead;        // redirect happened after the grant
  bit          m_held;
  logic [31:0] m_held_instr;
  logic [31:0] m_held_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, advance the model.
  task automatic cyc(input logic r, input logic s, input logic p, input logic [31:0] t,
                     input logic g, input logic v, input logic [31:0] d);
    logic        e_req, e_valid;
    logic [31:0] e_instr, e_pc;
    @(negedge clk);
    rst = r; StallF = s; PCSrcE = p; PCTargetE = t;
    imem_gnt = g; imem_rvalid = v; imem_rdata = d;
    #1;
    if (m_ok) begin
      e_req   = !m_out && !m_held;
      e_valid = 1'b0;
      e_instr = NOP;
      e_pc    = '0;
      if (!p && m_held) begin
        e_valid = 1'b1; e_instr = m_held_instr; e_pc = m_held_pc;
      end else if (!p && m_out && v && !m_out_dead) begin
        e_valid = 1'b1; e_instr = d; e_pc = m_out_pc;
      end
      chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
      if (e_req) chk("imem_addr", imem_addr, m_pc & 32'hFFFF_FFFC);
      chk("validF", {31'd0, validF}, {31'd0, e_valid});
      chk("instrF", instrF, e_instr);
      if (e_valid) begin
        chk("PCF", PCF, e_pc);
        chk("PCPulse4F", PCPulse4F, e_pc + 32'd4);
      end else if (m_after_rst) begin
        chk("PCF_reset", PCF, RESET_PC);
        chk("PCPulse4F_reset", PCPulse4F, RESET_PC + 32'd4);
      end
    end
    m_after_rst = 0;
    if (r) begin
      m_ok = 1; m_after_rst = 1;
      m_pc = RESET_PC; m_out = 0; m_out_dead = 0; m_held = 0;
    end else if (m_held) begin
      if (p)       begin m_held = 0; m_pc = t; end
      else if (!s) begin m_held = 0; m_pc = m_held_pc + 32'd4; end
    end else if (m_out) begin
      if (v) begin
        m_out = 0;
        if (m_out_dead)  begin m_out_dead = 0; if (p) m_pc = t; end
        else if (p)      m_pc = t;
        else if (s)      begin m_held = 1; m_held_instr = d; m_held_pc = m_out_pc; end
        else             m_pc = m_out_pc + 32'd4;
      end else if (p) begin
        m_out_dead = 1; m_pc = t;
      end
    end else begin
      if (g) begin m_out = 1; m_out_pc = m_pc; m_out_dead = p; end
      if (p) m_pc = t;
    end
  endtask

  initial begin
    logic        rs, st, ps, gg, vv;
    logic [31:0] tg;

    // Reset, then basic fetch at 0 and 4
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 0 granted
    cyc(0, 0, 0, 0, 0, 1, 32'h0050_0093);            // pass-through, PCF=0
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 4
    cyc(0, 0, 0, 0, 0, 1, 32'h1111_1111);
    // Stall on response at 8
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 8
    cyc(0, 1, 0, 0, 0, 1, 32'h2222_2222);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);                        // release, still valid
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 12
    cyc(0, 0, 0, 0, 0, 1, 32'h3333_3333);
    // Redirect while waiting
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 16
    cyc(0, 0, 1, 32'h100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);            // dropped
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 0x100
    cyc(0, 0, 0, 0, 0, 1, 32'h4444_4444);            // PCF=0x100
    // Redirect together with rvalid and stall
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 0x104
    cyc(0, 1, 1, 32'h200, 0, 1, 32'h5555_5555);      // no HOLD entry
    cyc(0, 1, 0, 0, 1, 0, 0);                        // addr 0x200
    cyc(0, 0, 0, 0, 0, 1, 32'h6666_6666);
    // PC wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0);            // grant+redirect, killed
    cyc(0, 0, 0, 0, 0, 1, 32'h7777_7777);
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 0xFFFFFFFC
    cyc(0, 0, 0, 0, 0, 1, 32'h8888_8888);            // PCPulse4F=0
    cyc(0, 0, 0, 0, 1, 0, 0);                        // addr 0
    // Reset while holding
    cyc(0, 1, 0, 0, 0, 1, 32'h9999_9999);            // enter HOLD
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);                        // IDLE, NOP, PCF=RESET_PC

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 2) == 0);
      ps = ($urandom_range(0, 7) == 0);
      tg = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0) | ($urandom & 32'h0000_0FFC);
      gg = (!m_out && !m_held) ? ($urandom_range(0, 1) == 1) : 1'b0;
      vv = m_out ? ($urandom_range(0, 2) == 0) : 1'b0;
      cyc(rs, st, ps, tg, gg, vv, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
